// File: rtl/cond_exec_unit.sv
// Execute-stage condition evaluation with banked NZCV flags and predicated blocks.
// Gated write intents are registered with one cycle of latency.
module cond_exec_unit #(
    parameter int NUM_BANKS = 2,
    parameter int MAX_BLOCK = 4,
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int LW = $clog2(MAX_BLOCK + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [3:0]           cond_i,
    input  logic [BW-1:0]        bank_sel_i,
    input  logic [3:0]           alu_flags_i,
    input  logic [1:0]           flag_write_i,
    input  logic                 pcs_i,
    input  logic                 reg_write_i,
    input  logic                 mem_write_i,
    input  logic                 blk_start_i,
    input  logic [LW-1:0]        blk_len_i,
    input  logic [3:0]           blk_cond_i,
    input  logic [MAX_BLOCK-1:0] blk_mask_i,
    output logic                 cond_ex_o,
    output logic                 pcs_o,
    output logic                 reg_write_o,
    output logic                 mem_write_o,
    output logic                 valid_o,
    output logic [3:0]           flags_o,
    output logic                 blk_active_o
);

    logic [3:0]           banks [NUM_BANKS];
    logic [3:0]           cur_flags;
    logic [3:0]           blk_cond_q;
    logic [MAX_BLOCK-1:0] blk_mask_q;
    logic [LW-1:0]        slot;
    logic [LW-1:0]        remaining;
    logic [LW-1:0]        len_clamped;
    logic                 mask_bit;
    logic                 use_blk;
    logic [3:0]           eff_cond;
    logic                 ce;
    logic                 accept;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, ge, r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        ge = (n == v);
        case (c)
            4'h0:    r = z;
            4'h1:    r = ~z;
            4'h2:    r = cy;
            4'h3:    r = ~cy;
            4'h4:    r = n;
            4'h5:    r = ~n;
            4'h6:    r = v;
            4'h7:    r = ~v;
            4'h8:    r = cy & ~z;
            4'h9:    r = ~(cy & ~z);
            4'hA:    r = ge;
            4'hB:    r = ~ge;
            4'hC:    r = ~z & ge;
            4'hD:    r = ~(~z & ge);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        cur_flags = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (bank_sel_i == BW'(b)) cur_flags = banks[b];
        end
    end

    always_comb begin
        mask_bit = 1'b0;
        for (int unsigned k = 0; k < MAX_BLOCK; k++) begin
            if (slot == LW'(k)) mask_bit = blk_mask_q[k];
        end
    end

    // A start instruction is never predicated, even when it aborts an open block.
    assign use_blk     = blk_active_o & ~blk_start_i;
    assign eff_cond    = use_blk ? {blk_cond_q[3:1], blk_cond_q[0] ^ mask_bit} : cond_i;
    assign ce          = valid_i & cond_pass(eff_cond, cur_flags);
    assign accept      = valid_i & ~stall_i & ~flush_i;
    assign len_clamped = (blk_len_i > LW'(MAX_BLOCK)) ? LW'(MAX_BLOCK) : blk_len_i;
    assign flags_o     = cur_flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o     <= 1'b0;
            cond_ex_o   <= 1'b0;
            pcs_o       <= 1'b0;
            reg_write_o <= 1'b0;
            mem_write_o <= 1'b0;
        end else if (flush_i) begin
            valid_o     <= 1'b0;
            cond_ex_o   <= 1'b0;
            pcs_o       <= 1'b0;
            reg_write_o <= 1'b0;
            mem_write_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o     <= valid_i;
            cond_ex_o   <= ce;
            pcs_o       <= pcs_i & ce;
            reg_write_o <= reg_write_i & ce;
            mem_write_o <= mem_write_i & ce;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_active_o <= 1'b0;
            blk_cond_q   <= '0;
            blk_mask_q   <= '0;
            slot         <= '0;
            remaining    <= '0;
        end else if (flush_i) begin
            blk_active_o <= 1'b0;
            slot         <= '0;
            remaining    <= '0;
        end else if (accept) begin
            if (blk_start_i) begin
                blk_cond_q   <= blk_cond_i;
                blk_mask_q   <= blk_mask_i;
                slot         <= '0;
                remaining    <= len_clamped;
                blk_active_o <= (len_clamped != '0);
            end else if (blk_active_o) begin
                slot      <= slot + LW'(1);
                remaining <= remaining - LW'(1);
                if (remaining == LW'(1)) blk_active_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) banks[b] <= '0;
        end else if (accept && ce) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (bank_sel_i == BW'(b)) begin
                    if (flag_write_i[1]) banks[b][3:2] <= alu_flags_i[3:2];
                    if (flag_write_i[0]) banks[b][1:0] <= alu_flags_i[1:0];
                end
            end
        end
    end

endmodule
